// File: rtl/piso_shift_pkg.sv
// Shared constants for the PISO serializer controller: FSM encodings and default word width.
package piso_shift_pkg;
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SHIFT   = 1'b1;
    localparam int         PISO_WIDTH = 4;
endpackage

// File: rtl/piso_shift_ctrl_if.sv
// Word-in / bit-out handshake bundle between producer, serializer and serial consumer.
interface piso_shift_ctrl_if #(parameter int WIDTH = piso_shift_pkg::PISO_WIDTH);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_shift_ctrl_shift_reg_left.sv
// Left shift register with parallel load; load wins over shift, zeros enter at the LSB.
module shift_reg_left #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (load)
            r_q <= d;
        else if (shift)
            r_q <= {r_q[WIDTH-2:0], 1'b0};
    end

    assign q = r_q;
endmodule

// File: rtl/piso_shift_ctrl.sv
// PISO serializer controller: accepts words, sends them MSB-first with a last-bit marker,
// and owns every load/shift enable of the shift register.
module piso_shift_ctrl
    import piso_shift_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input logic              clk,
    input logic              rst,
    piso_shift_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_q;
    logic             w_shifting;
    logic             w_cnt_zero;
    logic             w_beat;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_beat     = w_shifting && bus.ser_ready;
    assign w_in_ready = !rst && (!w_shifting || (w_cnt_zero && bus.ser_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_load     = w_accept;
    // On the final beat without a new word, one more shift flushes the last bit,
    // leaving the register cleared as the controller drops to IDLE.
    assign w_shift    = w_beat && !w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= ST_SHIFT;
            r_cnt   <= CW'(WIDTH - 1);
        end else if (w_beat) begin
            if (w_cnt_zero)
                r_state <= ST_IDLE;
            else
                r_cnt <= r_cnt - 1'b1;
        end
    end

    shift_reg_left #(.WIDTH(WIDTH)) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (bus.in_data),
        .q     (w_q)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.ser_valid = w_shifting;
    assign bus.busy      = w_shifting;
    assign bus.ser_out   = w_q[WIDTH-1] && w_shifting;
    assign bus.ser_last  = w_shifting && w_cnt_zero;
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Directed bench for piso_shift_ctrl: inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_piso_shift_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    piso_shift_ctrl_if #(.WIDTH(4)) bus ();

    piso_shift_ctrl #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1111;
        bus.ser_ready = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL reset_in_ready cyc%0d: got %b want 0", i, bus.in_ready);
            end
            n_cmp++;
            if (bus.ser_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ser_valid cyc%0d: got %b want 0", i, bus.ser_valid);
            end
            next_cycle();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.ser_valid, bus.ser_out, bus.ser_last, bus.busy, bus.in_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_release: got valid/out/last/busy/ready=%b want 00001",
                     {bus.ser_valid, bus.ser_out, bus.ser_last, bus.busy, bus.in_ready});
        end
        next_cycle();
    endtask

    task automatic test_single();
        logic [3:0] exp_out;
        logic [3:0] exp_last;
        logic [3:0] exp_rdy;
        exp_out  = 4'b1000;
        exp_last = 4'b0001;
        exp_rdy  = 4'b0001;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1000;
        bus.ser_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: in_ready got %b want 1", bus.in_ready);
        end
        next_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_valid, bus.busy, bus.ser_out, bus.ser_last, bus.in_ready} !==
                {2'b11, exp_out[3-i], exp_last[3-i], exp_rdy[3-i]}) begin
                n_err++;
                $display("FAIL single_bit%0d: got valid/busy/out/last/ready=%b want 11%b%b%b", i,
                         {bus.ser_valid, bus.busy, bus.ser_out, bus.ser_last, bus.in_ready},
                         exp_out[3-i], exp_last[3-i], exp_rdy[3-i]);
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.ser_valid, bus.ser_out} !== 3'b000) begin
            n_err++;
            $display("FAIL single_idle: got busy/valid/out=%b want 000",
                     {bus.busy, bus.ser_valid, bus.ser_out});
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out;
        logic [7:0] exp_last;
        exp_out  = 8'b1011_0110;
        exp_last = 8'b0001_0001;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1011;
        bus.ser_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: in_ready got %b want 1", bus.in_ready);
        end
        next_cycle();
        bus.in_data = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_valid, bus.ser_out, bus.ser_last} !== {1'b1, exp_out[7-i], exp_last[7-i]}) begin
                n_err++;
                $display("FAIL b2b_bit%0d: got valid/out/last=%b want 1%b%b", i,
                         {bus.ser_valid, bus.ser_out, bus.ser_last}, exp_out[7-i], exp_last[7-i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_second_accept: in_ready got %b want 1", bus.in_ready);
                end
            end
            next_cycle();
            if (i == 3) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (bus.ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: ser_valid got %b want 0", bus.ser_valid);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [6:0] rdy_seq;
        logic [6:0] exp_out;
        logic [6:0] exp_last;
        logic [6:0] exp_rdy;
        logic [3:0] got;
        int         n_got;
        rdy_seq  = 7'b1001101;
        exp_out  = 7'b1111011;
        exp_last = 7'b0000011;
        exp_rdy  = 7'b0000001;
        got      = '0;
        n_got    = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1101;
        bus.ser_ready = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.ser_ready = rdy_seq[6-i];
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_out, bus.ser_last, bus.in_ready} !== {exp_out[6-i], exp_last[6-i], exp_rdy[6-i]}) begin
                n_err++;
                $display("FAIL bp_cyc%0d: got out/last/ready=%b want %b%b%b", i,
                         {bus.ser_out, bus.ser_last, bus.in_ready},
                         exp_out[6-i], exp_last[6-i], exp_rdy[6-i]);
            end
            if (bus.ser_valid && bus.ser_ready) begin
                got   = {got[2:0], bus.ser_out};
                n_got++;
            end
            next_cycle();
        end
        bus.ser_ready = 1'b1;
        n_cmp++;
        if (n_got != 4 || got !== 4'b1101) begin
            n_err++;
            $display("FAIL bp_consumed: got %0d beats %b want 4 beats 1101", n_got, got);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: ser_valid got %b want 0", bus.ser_valid);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_out;
        exp_out = 4'b0111;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1010;
        bus.ser_ready = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_valid, bus.ser_out} !== {1'b1, (i == 0) ? 1'b1 : 1'b0}) begin
                n_err++;
                $display("FAIL rmid_bit%0d: got valid/out=%b want 1%b", i,
                         {bus.ser_valid, bus.ser_out}, (i == 0) ? 1'b1 : 1'b0);
            end
            next_cycle();
        end
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_in_ready_rst: got %b want 0", bus.in_ready);
        end
        next_cycle();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.ser_valid, bus.ser_out, bus.ser_last, bus.in_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL rmid_after_rst: got valid/out/last/ready=%b want 0001",
                     {bus.ser_valid, bus.ser_out, bus.ser_last, bus.in_ready});
        end
        next_cycle();
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0111;
        next_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_valid, bus.ser_out, bus.ser_last} !== {1'b1, exp_out[3-i], (i == 3) ? 1'b1 : 1'b0}) begin
                n_err++;
                $display("FAIL rmid_word2_bit%0d: got valid/out/last=%b want 1%b%b", i,
                         {bus.ser_valid, bus.ser_out, bus.ser_last}, exp_out[3-i], (i == 3) ? 1'b1 : 1'b0);
            end
            next_cycle();
        end
    endtask

    task automatic test_ignored_request();
        logic [7:0] exp_out;
        logic [7:0] exp_rdy;
        exp_out = 8'b1001_1111;
        exp_rdy = 8'b0001_0001;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1001;
        bus.ser_ready = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 4'b1111;
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.ser_valid, bus.ser_out, bus.in_ready, bus.ser_last} !==
                {1'b1, exp_out[7-i], exp_rdy[7-i], exp_rdy[7-i]}) begin
                n_err++;
                $display("FAIL ign_cyc%0d: got valid/out/ready/last=%b want 1%b%b%b", i,
                         {bus.ser_valid, bus.ser_out, bus.in_ready, bus.ser_last},
                         exp_out[7-i], exp_rdy[7-i], exp_rdy[7-i]);
            end
            next_cycle();
            if (i == 3) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ign_idle: busy got %b want 0", bus.busy);
        end
        next_cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ser_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_ignored_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
